// File: rtl/cpu_pipe_pkg.sv
// Shared defaults and FSM state encoding for the pipeline hazard/stall controller.
package cpu_pipe_pkg;

  localparam int unsigned REG_AW_DEFAULT   = 5;
  localparam int unsigned LOAD_LAT_DEFAULT = 1;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_LU_WAIT = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use and branch-operand stalls, memory freeze, branch flush
// and a saturating count of cycles in which the PC did not advance.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEFAULT,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter bit          BR_IN_ID = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memread_i,
  input  logic              idex_regwrite_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_branch_i,
  input  logic              branch_taken_i,
  input  logic              dmem_stall_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  if (LOAD_LAT == 0 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("LOAD_LAT must be in 1..15");
  end

  localparam logic [3:0] LatInit = 4'(LOAD_LAT - 1);

  logic       state_q;
  logic [3:0] lat_cnt_q;
  logic       rs_hit, rt_hit, lu_haz, br_haz, stall;

  assign rs_hit = (idex_rd_i == ifid_rs_i) && (idex_rd_i != '0);
  assign rt_hit = (idex_rd_i == ifid_rt_i) && (idex_rd_i != '0);
  assign lu_haz = idex_memread_i && (rs_hit || rt_hit);
  assign br_haz = BR_IN_ID && ifid_branch_i && idex_regwrite_i && !idex_memread_i &&
                  (rs_hit || rt_hit);
  assign stall  = (state_q == ST_LU_WAIT) || lu_haz || br_haz;

  // First stall cycle is spent in RUN, so LU_WAIT only covers the remaining LOAD_LAT-1 cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      lat_cnt_q <= '0;
    end else if (!dmem_stall_i) begin
      if (state_q == ST_RUN) begin
        if (lu_haz && (LOAD_LAT > 1)) begin
          state_q   <= ST_LU_WAIT;
          lat_cnt_q <= LatInit;
        end
      end else begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_q <= ST_RUN;
        end
      end
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (dmem_stall_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
    end else if (stall) begin
      // A taken branch is dropped here; it resolves again once its operands are ready.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (!pc_write_o && !rst_i),
    .clear_i (1'b0),
    .count_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl; four parameterisations share one stimulus.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, memread, regwrite, branch, taken, dmem;
  logic [4:0] rd, rs, rt;
  logic       pc_w [4];
  logic       ifid_w [4];
  logic       bub [4];
  logic       flush [4];
  logic       frz [4];
  logic [15:0] sc0, sc1, sc2;
  logic [2:0]  sc3;

  localparam int LAT  [4] = '{1, 3, 3, 1};
  localparam bit BRP  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam int CMAX [4] = '{65535, 65535, 65535, 7};

  int rem [4];
  int cnt [4];
  int n_cmp = 0;
  int n_err = 0;
  int d1_stalls = 0;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_IN_ID(1'b1), .CNT_W(16)) u_d0 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_regwrite_i(regwrite),
    .idex_rd_i(rd), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_branch_i(branch),
    .branch_taken_i(taken), .dmem_stall_i(dmem), .pc_write_o(pc_w[0]),
    .ifid_write_o(ifid_w[0]), .idex_bubble_o(bub[0]), .ifid_flush_o(flush[0]),
    .pipe_freeze_o(frz[0]), .stall_cnt_o(sc0));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_IN_ID(1'b1), .CNT_W(16)) u_d1 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_regwrite_i(regwrite),
    .idex_rd_i(rd), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_branch_i(branch),
    .branch_taken_i(taken), .dmem_stall_i(dmem), .pc_write_o(pc_w[1]),
    .ifid_write_o(ifid_w[1]), .idex_bubble_o(bub[1]), .ifid_flush_o(flush[1]),
    .pipe_freeze_o(frz[1]), .stall_cnt_o(sc1));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_IN_ID(1'b0), .CNT_W(16)) u_d2 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_regwrite_i(regwrite),
    .idex_rd_i(rd), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_branch_i(branch),
    .branch_taken_i(taken), .dmem_stall_i(dmem), .pc_write_o(pc_w[2]),
    .ifid_write_o(ifid_w[2]), .idex_bubble_o(bub[2]), .ifid_flush_o(flush[2]),
    .pipe_freeze_o(frz[2]), .stall_cnt_o(sc2));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_IN_ID(1'b1), .CNT_W(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_regwrite_i(regwrite),
    .idex_rd_i(rd), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_branch_i(branch),
    .branch_taken_i(taken), .dmem_stall_i(dmem), .pc_write_o(pc_w[3]),
    .ifid_write_o(ifid_w[3]), .idex_bubble_o(bub[3]), .ifid_flush_o(flush[3]),
    .pipe_freeze_o(frz[3]), .stall_cnt_o(sc3));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sc_of(input int k);
    case (k)
      0:       return int'(sc0);
      1:       return int'(sc1);
      2:       return int'(sc2);
      default: return int'(sc3);
    endcase
  endfunction

  // One pipeline cycle: drive at the falling edge, check settled outputs, then advance the model
  // to what the following rising edge should produce.
  task automatic step(input bit r, input bit mr, input bit rw, input int d, input int s,
                      input int t, input bit b, input bit tk, input bit dm);
    bit hit, lu, br;
    int e_pc, e_ifw, e_bub, e_fl, e_fz;
    @(negedge clk);
    rst = r; memread = mr; regwrite = rw; rd = 5'(d); rs = 5'(s); rt = 5'(t);
    branch = b; taken = tk; dmem = dm;
    #1;
    for (int k = 0; k < 4; k++) begin
      hit = (d != 0) && ((d == s) || (d == t));
      lu  = mr && hit;
      br  = BRP[k] && b && rw && !mr && hit;
      if (r) begin
        rem[k] = 0; cnt[k] = 0;
        e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_fz = 0;
      end else if (dm) begin
        e_pc = 0; e_ifw = 0; e_bub = 0; e_fl = 0; e_fz = 1;
      end else if (rem[k] > 0 || lu || br) begin
        e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_fz = 0;
      end else if (tk) begin
        e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 1; e_fz = 0;
      end else begin
        e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_fz = 0;
      end
      check($sformatf("d%0d.pc_write", k), int'(pc_w[k]), e_pc);
      check($sformatf("d%0d.ifid_write", k), int'(ifid_w[k]), e_ifw);
      check($sformatf("d%0d.idex_bubble", k), int'(bub[k]), e_bub);
      check($sformatf("d%0d.ifid_flush", k), int'(flush[k]), e_fl);
      check($sformatf("d%0d.pipe_freeze", k), int'(frz[k]), e_fz);
      check($sformatf("d%0d.stall_cnt", k), sc_of(k), cnt[k]);
      if (!r) begin
        if (e_pc == 0 && cnt[k] < CMAX[k]) cnt[k]++;
        if (!dm) begin
          if (rem[k] > 0) rem[k]--;
          else if (lu) rem[k] = LAT[k] - 1;
        end
      end
    end
    if (!r && !pc_w[1]) d1_stalls++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; memread = 0; regwrite = 0; rd = 0; rs = 0; rt = 0;
    branch = 0; taken = 0; dmem = 0;
    for (int k = 0; k < 4; k++) begin rem[k] = 0; cnt[k] = 0; end

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // load-use rd=8/rs=8 held one cycle, then cleared
    step(0, 1, 1, 8, 8, 0, 0, 0, 0);
    idle(4);
    // rd=0 never matches
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    // ALU producer feeding an ID-stage branch
    step(0, 0, 1, 5, 0, 5, 1, 0, 0);
    idle(1);
    // taken branch without and with a load-use hazard
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 3, 3, 0, 1, 1, 0);
    idle(4);

    // LOAD_LAT=3 stall with a 4-cycle memory freeze in the middle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    d1_stalls = 0;
    step(0, 1, 1, 8, 8, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    check("freeze_total_stalls", d1_stalls, 7);
    check("freeze_stall_cnt", int'(sc1), 7);

    // reset in the middle of LU_WAIT
    step(0, 1, 1, 9, 0, 9, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("post_reset_run", int'(pc_w[1]), 1);

    // CNT_W=3 counter saturation
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 8, 8, 0, 0, 0, 0);
    idle(1);
    check("sat_cnt3", int'(sc3), 7);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
